vga_pattern_generator: RTL and testbench
========================================

VGA_PATTERN_GENERATOR -- requirements
Module: vga_pattern_generator

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-003 Parameter BAR_WIDTH, default 80, pixel width of one colour bar; H_ACTIVE SHALL equal 8*BAR_WIDTH.
REQ-004 CLK  input  1  sole clock; all state SHALL update on the rising edge.
REQ-005 RESETN  input  1  synchronous, active-low reset.
REQ-006 ADDRESS_H  input  10  current pixel column from the VGA timing stage.
REQ-007 ADDRESS_V  input  9  current pixel row from the VGA timing stage.
REQ-008 COLOUR_IN  input  12  user colour, {R[3:0],G[3:0],B[3:0]}.
REQ-009 MODE_NEXT  input  1  level input from a debounced button; each rising edge requests the next mode.
REQ-010 COLOUR_OUT  output  12  registered pixel colour to the VGA timing stage.
REQ-011 MODE  output  2  current pattern mode.
REQ-012 FRAME_COUNT  output  8  frames since reset, modulo 256.

Function
REQ-013 Frame start SHALL be a one-cycle internal pulse, asserted when (ADDRESS_H,ADDRESS_V)=(0,0) and the registered address from the previous cycle is not (0,0).
REQ-014 At each frame start, FRAME_COUNT SHALL increment by 1 and wrap from 255 to 0.
REQ-015 At each frame start, scroll offset (10-bit, internal) SHALL increment by 1 and wrap from H_ACTIVE-1 to 0.
REQ-016 MODE states: 0 SOLID, 1 BARS, 2 CHECKER, 3 SCROLL. Sequence SHALL be 0->1->2->3->0.
REQ-017 A MODE_NEXT rising edge SHALL be detected against a registered copy of MODE_NEXT and SHALL set a pending flag.
REQ-018 At a frame start with pending=1, MODE SHALL advance one step and pending SHALL clear. MODE SHALL never change at any other time.
REQ-019 Multiple MODE_NEXT edges in one frame SHALL produce exactly one step.
REQ-020 An edge detected in the same cycle as a frame start SHALL NOT apply at that frame start. It SHALL remain pending and apply at the following frame start.
REQ-021 COLOUR_OUT SHALL be a function of the address one cycle earlier (latency 1 clock).
REQ-022 Outside the active area (ADDRESS_H>=H_ACTIVE or ADDRESS_V>=V_ACTIVE), COLOUR_OUT SHALL be 12'h000.
REQ-023 SOLID: COLOUR_OUT SHALL be COLOUR_IN.
REQ-024 BARS: bar index = ADDRESS_H/BAR_WIDTH. Index 0..7 SHALL map to FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
REQ-025 CHECKER: COLOUR_OUT SHALL be COLOUR_IN when ADDRESS_H[5]^ADDRESS_V[5]=0, else bitwise ~COLOUR_IN (32x32 squares).
REQ-026 SCROLL: as BARS, with the column replaced by (ADDRESS_H+offset) mod H_ACTIVE. The sum SHALL be computed at 11 bits and have H_ACTIVE subtracted if >=H_ACTIVE.
REQ-027 The offset value used SHALL be the value held before the current frame start's update, so that it is constant across every pixel of a frame.
REQ-028 MODE and FRAME_COUNT outputs SHALL be driven directly from registers.

Reset
REQ-029 While RESETN=0 at a clock edge, the following SHALL hold on the next cycle: COLOUR_OUT=000, MODE=0, FRAME_COUNT=0, offset=0, pending=0, registered MODE_NEXT=0, registered address=(0,0).
REQ-030 A first address of (0,0) after reset SHALL NOT generate a frame start.
REQ-031 Reset asserted mid-frame or mid-pending SHALL discard the pending request and all counts, with no further effect.

Verification
REQ-032 Reset, then MODE=0 with COLOUR_IN=12'h5A3 and address (10,10) -> COLOUR_OUT=5A3 one cycle later; address (700,10) -> COLOUR_OUT=000.
REQ-033 MODE=1, sweep ADDRESS_H 0..639 on row 0 -> COLOUR_OUT steps FFF,FF0,0FF,0F0,F0F,F00,00F,000 at columns 0,80,...,560, each one cycle late.
REQ-034 MODE=2 with COLOUR_IN=12'h0F0 -> (0,0)=0F0, (32,0)=F0F, (32,32)=0F0.
REQ-035 Three MODE_NEXT pulses mid-frame -> MODE stays 0 until the next (0,0) entry, then becomes 1 (single step). A pulse coincident with a frame start -> MODE changes only at the subsequent frame start.
REQ-036 MODE=3 after 5 frame starts (offset=5) -> (75,0)=FF0, (635,0)=FFF. Run 640 frames -> offset returns to 0. Run 256 frames -> FRAME_COUNT wraps to 0.
REQ-037 Assert RESETN=0 for one cycle mid-frame with pending=1 and MODE=2 -> MODE=0, FRAME_COUNT=0, and no mode step at the next frame start.

Source files
------------

// File: rtl/vga_pattern_generator.sv
// ============================================================================
// Module   : vga_pattern_generator
// Brief    : Test-pattern source (solid/bars/checker/scroll) for a VGA timing stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_pattern_generator #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int BAR_WIDTH = 80
) (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic [9:0]  ADDRESS_H,
    input  logic [8:0]  ADDRESS_V,
    input  logic [11:0] COLOUR_IN,
    input  logic        MODE_NEXT,
    output logic [11:0] COLOUR_OUT,
    output logic [1:0]  MODE,
    output logic [7:0]  FRAME_COUNT
);

    localparam logic [9:0]  c_h_active = 10'(H_ACTIVE);
    localparam logic [8:0]  c_v_active = 9'(V_ACTIVE);
    localparam logic [10:0] c_h_active_wide = 11'(H_ACTIVE);

    typedef enum logic [1:0] {
        MODE_SOLID   = 2'd0,
        MODE_BARS    = 2'd1,
        MODE_CHECKER = 2'd2,
        MODE_SCROLL  = 2'd3
    } mode_t;

    mode_t       r_mode;
    mode_t       w_mode_next;
    logic [9:0]  r_addr_h;
    logic [8:0]  r_addr_v;
    logic        r_mode_next_q;
    logic        r_pending;
    logic [9:0]  r_offset;
    logic [7:0]  r_frame_count;
    logic [11:0] r_colour;

    logic        w_frame_start;
    logic        w_edge;
    logic        w_active;
    logic [10:0] w_scroll_sum;
    logic [9:0]  w_scroll_col;
    logic [11:0] w_colour;

    // Maps a visible column to its colour bar via a threshold chain.
    function automatic logic [11:0] bar_colour(input logic [9:0] col);
        logic [2:0] idx;
        idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (col >= 10'(k * BAR_WIDTH)) begin
                idx = 3'(k);
            end
        end
        case (idx)
            3'd0:    bar_colour = 12'hFFF;
            3'd1:    bar_colour = 12'hFF0;
            3'd2:    bar_colour = 12'h0FF;
            3'd3:    bar_colour = 12'h0F0;
            3'd4:    bar_colour = 12'hF0F;
            3'd5:    bar_colour = 12'hF00;
            3'd6:    bar_colour = 12'h00F;
            default: bar_colour = 12'h000;
        endcase
    endfunction

    // The registered address resets to (0,0), so the first (0,0) after reset is not a frame start.
    assign w_frame_start = (ADDRESS_H == 10'd0) && (ADDRESS_V == 9'd0) &&
                           !((r_addr_h == 10'd0) && (r_addr_v == 9'd0));
    assign w_edge        = MODE_NEXT && !r_mode_next_q;
    assign w_active      = (ADDRESS_H < c_h_active) && (ADDRESS_V < c_v_active);

    // r_offset still holds the pre-update value during a frame-start cycle.
    assign w_scroll_sum  = {1'b0, ADDRESS_H} + {1'b0, r_offset};
    assign w_scroll_col  = (w_scroll_sum >= c_h_active_wide) ?
                           10'(w_scroll_sum - c_h_active_wide) : w_scroll_sum[9:0];

    always_comb begin
        w_colour = 12'h000;
        if (w_active) begin
            case (r_mode)
                MODE_SOLID:   w_colour = COLOUR_IN;
                MODE_BARS:    w_colour = bar_colour(ADDRESS_H);
                MODE_CHECKER: w_colour = (ADDRESS_H[5] ^ ADDRESS_V[5]) ? ~COLOUR_IN : COLOUR_IN;
                MODE_SCROLL:  w_colour = bar_colour(w_scroll_col);
                default:      w_colour = 12'h000;
            endcase
        end
    end

    always_comb begin
        w_mode_next = r_mode;
        if (w_frame_start && r_pending) begin
            case (r_mode)
                MODE_SOLID:   w_mode_next = MODE_BARS;
                MODE_BARS:    w_mode_next = MODE_CHECKER;
                MODE_CHECKER: w_mode_next = MODE_SCROLL;
                MODE_SCROLL:  w_mode_next = MODE_SOLID;
                default:      w_mode_next = MODE_SOLID;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            r_mode <= MODE_SOLID;
        end else begin
            r_mode <= w_mode_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            r_addr_h      <= 10'd0;
            r_addr_v      <= 9'd0;
            r_mode_next_q <= 1'b0;
            r_pending     <= 1'b0;
            r_offset      <= 10'd0;
            r_frame_count <= 8'd0;
            r_colour      <= 12'h000;
        end else begin
            r_addr_h      <= ADDRESS_H;
            r_addr_v      <= ADDRESS_V;
            r_mode_next_q <= MODE_NEXT;
            r_colour      <= w_colour;
            if (w_frame_start) begin
                // An edge coincident with the frame start carries over to the next one.
                r_pending     <= w_edge;
                r_frame_count <= r_frame_count + 8'd1;
                r_offset      <= (r_offset == c_h_active - 10'd1) ? 10'd0 : r_offset + 10'd1;
            end else if (w_edge) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign COLOUR_OUT  = r_colour;
    assign MODE        = r_mode;
    assign FRAME_COUNT = r_frame_count;

endmodule

`default_nettype wire

// File: tb/tb_vga_pattern_generator.sv
// ============================================================================
// Module   : tb_vga_pattern_generator
// Brief    : Directed self-checking bench for vga_pattern_generator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_pattern_generator;

    logic        clk = 1'b0;
    logic        rstn;
    logic [9:0]  addr_h;
    logic [8:0]  addr_v;
    logic [11:0] colour_in;
    logic        mode_next;
    logic [11:0] colour_out;
    logic [1:0]  mode;
    logic [7:0]  frame_count;

    int vectors     = 0;
    int miscompares = 0;

    logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                              12'hF0F, 12'hF00, 12'h00F, 12'h000};

    always #5 clk = ~clk;

    vga_pattern_generator #(
        .H_ACTIVE  (640),
        .V_ACTIVE  (480),
        .BAR_WIDTH (80)
    ) dut (
        .CLK         (clk),
        .RESETN      (rstn),
        .ADDRESS_H   (addr_h),
        .ADDRESS_V   (addr_v),
        .COLOUR_IN   (colour_in),
        .MODE_NEXT   (mode_next),
        .COLOUR_OUT  (colour_out),
        .MODE        (mode),
        .FRAME_COUNT (frame_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_addr(input int h, input int v);
        addr_h = 10'(h);
        addr_v = 9'(v);
    endtask

    // One frame start: leave (0,0), then re-enter it.
    task automatic frame();
        set_addr(1, 0);
        tick();
        set_addr(0, 0);
        tick();
    endtask

    task automatic pulse();
        mode_next = 1'b1;
        tick();
        mode_next = 1'b0;
        tick();
    endtask

    initial begin
        rstn      = 1'b0;
        mode_next = 1'b0;
        colour_in = 12'h5A3;
        set_addr(0, 0);
        tick();
        tick();
        check("reset_colour", colour_out, 12'h000);
        check("reset_mode", {10'd0, mode}, 12'd0);
        check("reset_fc", {4'd0, frame_count}, 12'd0);

        rstn = 1'b1;
        tick();
        check("first_00_no_frame", {4'd0, frame_count}, 12'd0);
        check("solid_00", colour_out, 12'h5A3);
        set_addr(10, 10);
        tick();
        check("solid_10_10", colour_out, 12'h5A3);
        set_addr(700, 10);
        tick();
        check("solid_700_10_blank", colour_out, 12'h000);
        set_addr(10, 480);
        tick();
        check("solid_10_480_blank", colour_out, 12'h000);

        // Three pulses in one frame give a single step at the next frame start.
        set_addr(10, 10);
        tick();
        pulse();
        pulse();
        pulse();
        check("mode_held_midframe", {10'd0, mode}, 12'd0);
        set_addr(0, 0);
        tick();
        check("mode_step_once", {10'd0, mode}, 12'd1);
        check("fc_after_1", {4'd0, frame_count}, 12'd1);
        frame();
        check("mode_single_step", {10'd0, mode}, 12'd1);
        check("fc_after_2", {4'd0, frame_count}, 12'd2);

        for (int h = 0; h < 640; h++) begin
            set_addr(h, 0);
            tick();
            if ((h % 80) == 0 || (h % 80) == 79) begin
                check($sformatf("bars_col_%0d", h), colour_out, bars[h / 80]);
            end
        end

        colour_in = 12'h0F0;
        pulse();
        frame();
        check("mode_checker", {10'd0, mode}, 12'd2);
        tick();
        check("checker_0_0", colour_out, 12'h0F0);
        set_addr(32, 0);
        tick();
        check("checker_32_0", colour_out, 12'hF0F);
        set_addr(32, 32);
        tick();
        check("checker_32_32", colour_out, 12'h0F0);
        set_addr(0, 32);
        tick();
        check("checker_0_32", colour_out, 12'hF0F);

        // Edge coincident with a frame start is deferred by one frame.
        set_addr(1, 0);
        tick();
        set_addr(0, 0);
        mode_next = 1'b1;
        tick();
        check("coincident_no_step", {10'd0, mode}, 12'd2);
        check("fc_after_4", {4'd0, frame_count}, 12'd4);
        mode_next = 1'b0;
        frame();
        check("coincident_deferred_step", {10'd0, mode}, 12'd3);
        check("fc_after_5", {4'd0, frame_count}, 12'd5);

        set_addr(75, 0);
        tick();
        check("scroll5_75", colour_out, 12'hFF0);
        set_addr(74, 0);
        tick();
        check("scroll5_74", colour_out, 12'hFFF);
        set_addr(635, 0);
        tick();
        check("scroll5_635", colour_out, 12'hFFF);
        set_addr(634, 0);
        tick();
        check("scroll5_634", colour_out, 12'h000);

        for (int i = 0; i < 251; i++) frame();
        check("fc_wrap_256", {4'd0, frame_count}, 12'd0);
        set_addr(384, 0);
        tick();
        check("scroll256_384", colour_out, 12'hFFF);
        set_addr(383, 0);
        tick();
        check("scroll256_383", colour_out, 12'h000);

        for (int i = 0; i < 384; i++) frame();
        check("fc_after_640", {4'd0, frame_count}, 12'h080);
        set_addr(75, 0);
        tick();
        check("scroll0_75", colour_out, 12'hFFF);
        set_addr(80, 0);
        tick();
        check("scroll0_80", colour_out, 12'hFF0);
        set_addr(639, 0);
        tick();
        check("scroll0_639", colour_out, 12'h000);
        check("mode_still_scroll", {10'd0, mode}, 12'd3);

        pulse();
        frame();
        check("mode_wrap_to_solid", {10'd0, mode}, 12'd0);
        pulse();
        frame();
        pulse();
        frame();
        check("mode_back_to_checker", {10'd0, mode}, 12'd2);

        // Reset with a request pending must discard it.
        set_addr(10, 10);
        tick();
        pulse();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        check("midreset_mode", {10'd0, mode}, 12'd0);
        check("midreset_fc", {4'd0, frame_count}, 12'd0);
        check("midreset_colour", colour_out, 12'h000);
        frame();
        check("no_step_after_reset", {10'd0, mode}, 12'd0);
        check("fc_after_reset_frame", {4'd0, frame_count}, 12'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
